// File: rtl/ltoh_buf.sv
// ltoh_buf: samples slow wclk in the fast rclk domain, captures din on wclk
// edges into a show-ahead FIFO drained by valid/ready. Option: LTOH_DUAL_EDGE_EN
module ltoh_buf #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 8,
  parameter int ADD_WIDTH   = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  rclk,
  input  logic                  rst_n,
  input  logic                  wclk,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  pe,
  output logic                  full,
  output logic                  empty,
  output logic [ADD_WIDTH:0]    count,
  output logic                  ovf,
  input  logic                  ovf_clr
);

  localparam int ARM_MAX = SYNC_STAGES + 1;
  localparam int ARM_W   = $clog2(ARM_MAX + 1);
  localparam logic [ADD_WIDTH:0] CNT_FULL = (ADD_WIDTH+1)'(DEPTH);
  localparam logic [ARM_W-1:0]   ARM_TOP  = ARM_W'(ARM_MAX);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   h_q;
  logic                   s;
  logic [ARM_W-1:0]       arm_q;
  logic                   armed;
  logic                   rise;
  logic                   cap;
  logic                   push;
  logic                   pop;
  logic                   push_ok;
  logic                   drop;

  logic [DATA_WIDTH-1:0]  mem [DEPTH];
  logic [ADD_WIDTH-1:0]   wr_ptr;
  logic [ADD_WIDTH-1:0]   rd_ptr;

  assign s     = sync_q[SYNC_STAGES-1];
  assign rise  = s & ~h_q;
  assign armed = (arm_q == ARM_TOP);

`ifdef LTOH_DUAL_EDGE_EN
  assign cap = s ^ h_q;
`else
  assign cap = rise;
`endif

  assign pe      = rise & armed;
  assign push    = cap & armed;
  assign pop     = dout_valid & dout_ready;
  assign push_ok = push & (~full | pop);
  assign drop    = push & full & ~pop;

  assign empty      = (count == '0);
  assign full       = (count == CNT_FULL);
  assign dout_valid = ~empty;
  assign dout       = empty ? '0 : mem[rd_ptr];

  // wclk synchroniser, edge history and start-up arming counter
  always_ff @(posedge rclk) begin
    if (!rst_n) begin
      sync_q <= '0;
      h_q    <= 1'b0;
      arm_q  <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], wclk};
      h_q    <= s;
      if (!armed) arm_q <= arm_q + ARM_W'(1);
    end
  end

  // FIFO storage; left unreset, only count decides what is visible
  always_ff @(posedge rclk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  // FIFO pointers, occupancy and sticky overflow flag
  always_ff @(posedge rclk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + ADD_WIDTH'(1);
      if (pop)     rd_ptr <= rd_ptr + ADD_WIDTH'(1);
      unique case ({push_ok, pop})
        2'b10:   count <= count + (ADD_WIDTH+1)'(1);
        2'b01:   count <= count - (ADD_WIDTH+1)'(1);
        default: count <= count;
      endcase
      if (drop)         ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

endmodule
